wb_master_arbiter: RTL and testbench
====================================

WB_MASTER_ARBITER -- requirements
Module: wb_master_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 8'd200, meaning cycles a granted strobe may wait for ack before abort; legal range 1..255.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports m0_adr_i, m1_adr_i  input  16  master N address.
REQ-005 SHALL have ports m0_dat_i, m1_dat_i  input  8  master N write data.
REQ-006 SHALL have ports m0_we_i, m1_we_i  input  1  master N write enable.
REQ-007 SHALL have ports m0_cyc_i, m1_cyc_i and m0_stb_i, m1_stb_i  input  1 each  master N cycle and strobe.
REQ-008 SHALL have ports m0_dat_o, m1_dat_o  output  8  read data to master N.
REQ-009 SHALL have ports m0_ack_o, m1_ack_o  output  1  ack to master N.
REQ-010 SHALL have ports m0_err_o, m1_err_o  output  1  timeout abort to master N.
REQ-011 SHALL have ports s_adr_o 16, s_dat_o 8, s_we_o 1, s_cyc_o 1, s_stb_o 1  output  shared slave bus.
REQ-012 SHALL have ports s_dat_i 8, s_ack_i 1  input  slave read data and ack.
REQ-013 SHALL have port grant_o  output  2  one-hot current owner; 2'b00 = none.

Function
REQ-014 SHALL implement states IDLE, OWN, RECOVER in a registered state machine with a registered owner index and a registered last_owner bit.
REQ-015 Request N SHALL be defined as mN_cyc_i & mN_stb_i.
REQ-016 In IDLE with exactly one request, SHALL grant that master: next cycle state=OWN, grant_o one-hot, 1-cycle grant latency.
REQ-017 In IDLE with both requests, SHALL grant the master != last_owner (round robin); tie after reset goes to m0.
REQ-018 On each grant, last_owner SHALL be updated to the new owner.
REQ-019 In IDLE with no request, SHALL remain in IDLE, grant_o=00.
REQ-020 In OWN, s_adr_o, s_dat_o, s_we_o, s_cyc_o, s_stb_o SHALL combinationally follow the owner's inputs.
REQ-021 Outside OWN, all s_* outputs SHALL be 0.
REQ-022 Owner ack: SHALL drive m[owner]_ack_o = s_ack_i only when state=OWN and owner cyc&stb high.
REQ-023 Owner read data: SHALL drive m[owner]_dat_o = s_dat_i.
REQ-024 Non-owner ack/err SHALL be 0; non-owner dat_o SHALL be 8'h00.
REQ-025 Ownership SHALL be held (bus lock) while owner cyc is high, across multiple strobes.
REQ-026 When owner cyc is low in OWN, SHALL go to IDLE next cycle; the next arbitration occurs in IDLE, giving a minimum 1-cycle idle gap between owners.
REQ-027 An 8-bit wait counter SHALL clear on grant, on a forwarded ack, and whenever owner stb is low; it SHALL increment each OWN cycle with owner stb high and no ack.
REQ-028 When the wait counter equals TIMEOUT_CYCLES, SHALL assert m[owner]_err_o for exactly one cycle, force s_cyc_o/s_stb_o low from that cycle, and enter RECOVER.
REQ-029 In RECOVER, SHALL ignore s_ack_i (not forwarded) and hold grant_o until owner cyc is low, then go to IDLE.
REQ-030 If ack and the timeout compare coincide, ack SHALL win: ack forwarded, no err, counter cleared.
REQ-031 A request from the non-owner during OWN/RECOVER SHALL be held off (no ack/err) and served at the next IDLE.

Reset
REQ-032 While rst_n=0, SHALL asynchronously force state=IDLE, grant_o=00, last_owner=1, wait counter=0, all acks/errs 0, all s_* outputs 0; reset mid-transaction SHALL abort it with no ack.

Verification
REQ-033 m0 read 16'h1234, slave acks with 8'hA5 after 3 cycles -> grant_o=01 one cycle after request; s_adr_o=16'h1234; m0_ack_o pulses with m0_dat_o=8'hA5; m1 sees nothing.
REQ-034 m0 and m1 request in the same cycle, three times in a row (each releasing cyc after ack) -> grants in order m0, m1, m0; each separated by at least one IDLE cycle.
REQ-035 m1 holds cyc high for two writes (8'h11 to 16'h0010, 8'h22 to 16'h0011) while m0 requests -> m0 gets no grant until m1 drops cyc, then m0 is granted.
REQ-036 TIMEOUT_CYCLES=4, slave never acks -> m0_err_o pulses exactly once after 4 waiting cycles, s_stb_o low afterwards, a late s_ack_i is not forwarded, IDLE after m0 drops cyc.
REQ-037 rst_n driven low asynchronously mid-OWN -> grant_o=00 and s_cyc_o=0 immediately; after release, simultaneous requests grant m0 first.

Source files
------------

// File: rtl/wb_master_arbiter.sv
// wb_master_arbiter: two-master Wishbone arbiter onto one shared slave bus.
// Round-robin on simultaneous requests, bus lock while the owner holds cyc,
// and a per-strobe ack timeout that aborts the owner with a one-cycle err.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   mN_adr_i/dat_i/we_i        master N address, write data, write enable
//   mN_cyc_i/stb_i             master N cycle and strobe
//   mN_dat_o/ack_o/err_o       read data, ack, timeout abort to master N
//   s_adr_o/dat_o/we_o         shared slave bus address, data, write enable
//   s_cyc_o/stb_o              shared slave bus cycle and strobe
//   s_dat_i/ack_i              slave read data and ack
//   grant_o                    one-hot current owner, 2'b00 when idle
module wb_master_arbiter #(
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] m0_adr_i,
    input  logic [15:0] m1_adr_i,
    input  logic [7:0]  m0_dat_i,
    input  logic [7:0]  m1_dat_i,
    input  logic        m0_we_i,
    input  logic        m1_we_i,
    input  logic        m0_cyc_i,
    input  logic        m1_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m1_stb_i,
    output logic [7:0]  m0_dat_o,
    output logic [7:0]  m1_dat_o,
    output logic        m0_ack_o,
    output logic        m1_ack_o,
    output logic        m0_err_o,
    output logic        m1_err_o,
    output logic [15:0] s_adr_o,
    output logic [7:0]  s_dat_o,
    output logic        s_we_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    input  logic [7:0]  s_dat_i,
    input  logic        s_ack_i,
    output logic [1:0]  grant_o
);

    typedef enum logic [1:0] {IDLE, OWN, RECOVER} state_t;

    state_t      state, state_nxt;
    logic        owner, owner_nxt;
    logic        last_owner, last_owner_nxt;
    logic [7:0]  wait_cnt, wait_cnt_nxt;

    logic        req0, req1;
    logic        own_cyc, own_stb, own_we;
    logic [15:0] own_adr;
    logic [7:0]  own_dat;
    logic        ack_fwd, timeout;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;

    // Owner's request fields, selected by the registered owner index.
    assign own_cyc = owner ? m1_cyc_i : m0_cyc_i;
    assign own_stb = owner ? m1_stb_i : m0_stb_i;
    assign own_we  = owner ? m1_we_i  : m0_we_i;
    assign own_adr = owner ? m1_adr_i : m0_adr_i;
    assign own_dat = owner ? m1_dat_i : m0_dat_i;

    assign ack_fwd = (state == OWN) & own_cyc & own_stb & s_ack_i;
    // An ack arriving in the same cycle as the timeout compare wins.
    assign timeout = (state == OWN) & own_cyc & ~ack_fwd & (wait_cnt == TIMEOUT_CYCLES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;   // first tie after reset goes to m0
            wait_cnt   <= 8'd0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_owner_nxt;
            wait_cnt   <= wait_cnt_nxt;
        end
    end

    always_comb begin
        logic pick;
        state_nxt      = state;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        wait_cnt_nxt   = wait_cnt;
        pick           = 1'b0;
        case (state)
            IDLE: begin
                wait_cnt_nxt = 8'd0;
                if (req0 | req1) begin
                    pick           = (req0 & req1) ? ~last_owner : req1;
                    owner_nxt      = pick;
                    last_owner_nxt = pick;
                    state_nxt      = OWN;
                end
            end
            OWN: begin
                if (!own_cyc) begin
                    state_nxt    = IDLE;
                    wait_cnt_nxt = 8'd0;
                end else if (timeout) begin
                    state_nxt    = RECOVER;
                    wait_cnt_nxt = 8'd0;
                end else if (ack_fwd || !own_stb) begin
                    wait_cnt_nxt = 8'd0;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            RECOVER: begin
                // Grant held until the aborted master drops cyc.
                wait_cnt_nxt = 8'd0;
                if (!own_cyc) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grant_o  = 2'b00;
        s_adr_o  = 16'h0000;
        s_dat_o  = 8'h00;
        s_we_o   = 1'b0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        m0_dat_o = 8'h00;
        m1_dat_o = 8'h00;
        if (state != IDLE) begin
            grant_o = owner ? 2'b10 : 2'b01;
            if (owner) m1_dat_o = s_dat_i;
            else       m0_dat_o = s_dat_i;
        end
        if (state == OWN) begin
            s_adr_o = own_adr;
            s_dat_o = own_dat;
            s_we_o  = own_we;
            // Timeout withdraws the cycle from the slave in the same cycle.
            s_cyc_o = own_cyc & ~timeout;
            s_stb_o = own_stb & ~timeout;
        end
    end

    assign m0_ack_o = ack_fwd & ~owner;
    assign m1_ack_o = ack_fwd &  owner;
    assign m0_err_o = timeout & ~owner;
    assign m1_err_o = timeout &  owner;

endmodule

// File: tb/tb_wb_master_arbiter.sv
module tb_wb_master_arbiter;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] m0_adr_i = '0, m1_adr_i = '0;
    logic [7:0]  m0_dat_i = '0, m1_dat_i = '0;
    logic        m0_we_i = 0, m1_we_i = 0, m0_cyc_i = 0, m1_cyc_i = 0, m0_stb_i = 0, m1_stb_i = 0;
    logic [7:0]  m0_dat_o, m1_dat_o;
    logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
    logic [15:0] s_adr_o;
    logic [7:0]  s_dat_o;
    logic        s_we_o, s_cyc_o, s_stb_o;
    logic [7:0]  s_dat_i = '0;
    logic        s_ack_i = 0;
    logic [1:0]  grant_o;

    int errors = 0;
    int checks = 0;

    // behavioural reference state: owner -1 = bus free
    int mown;
    bit mrec, mlast, mfwd, merr;
    int mwait;

    wb_master_arbiter #(.TIMEOUT_CYCLES(8'(TMO))) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_adr_i(m0_adr_i), .m1_adr_i(m1_adr_i),
        .m0_dat_i(m0_dat_i), .m1_dat_i(m1_dat_i),
        .m0_we_i(m0_we_i), .m1_we_i(m1_we_i),
        .m0_cyc_i(m0_cyc_i), .m1_cyc_i(m1_cyc_i),
        .m0_stb_i(m0_stb_i), .m1_stb_i(m1_stb_i),
        .m0_dat_o(m0_dat_o), .m1_dat_o(m1_dat_o),
        .m0_ack_o(m0_ack_o), .m1_ack_o(m1_ack_o),
        .m0_err_o(m0_err_o), .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .grant_o(grant_o)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs;
        m0_adr_i = '0; m1_adr_i = '0; m0_dat_i = '0; m1_dat_i = '0;
        m0_we_i = 0; m1_we_i = 0; m0_cyc_i = 0; m1_cyc_i = 0; m0_stb_i = 0; m1_stb_i = 0;
        s_dat_i = '0; s_ack_i = 0;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    // Polls (bounded) from the current negedge until some master is granted.
    task automatic wait_grant(output logic [1:0] g, output bit idle_seen);
        int i;
        i = 0;
        idle_seen = 0;
        #1;
        while (grant_o == 2'b00 && i < 8) begin
            idle_seen = 1;
            @(negedge clk); #1;
            i++;
        end
        g = grant_o;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 0;
        m0_cyc_i = 1; m0_stb_i = 1; s_ack_i = 1;
        #1;
        checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL rst_grant: got %b want 00", grant_o); end
        checks++; if ({s_cyc_o, s_stb_o, s_adr_o} !== 18'h0) begin errors++; $display("FAIL rst_sbus: got cyc=%b stb=%b adr=%h want 0", s_cyc_o, s_stb_o, s_adr_o); end
        checks++; if ({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 4'b0) begin errors++; $display("FAIL rst_ackerr: got %b want 0000", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}); end
        clear_inputs();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_single_read;
        logic [1:0] g; bit idle;
        @(negedge clk);
        m0_adr_i = 16'h1234; m0_we_i = 0; m0_cyc_i = 1; m0_stb_i = 1;
        #1;
        checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL rd_lat0: got %b want 00", grant_o); end
        @(negedge clk);
        wait_grant(g, idle);
        checks++; if (g !== 2'b01 || idle) begin errors++; $display("FAIL rd_grant: got %b idle=%0d want 01 idle=0", g, idle); end
        checks++; if (s_adr_o !== 16'h1234 || s_cyc_o !== 1 || s_stb_o !== 1 || s_we_o !== 0) begin errors++; $display("FAIL rd_sbus: got adr=%h cyc=%b stb=%b we=%b", s_adr_o, s_cyc_o, s_stb_o, s_we_o); end
        repeat (2) @(negedge clk);
        s_ack_i = 1; s_dat_i = 8'hA5;
        #1;
        checks++; if (m0_ack_o !== 1 || m0_dat_o !== 8'hA5) begin errors++; $display("FAIL rd_ack: got ack=%b dat=%h want 1 a5", m0_ack_o, m0_dat_o); end
        checks++; if (m1_ack_o !== 0 || m1_dat_o !== 8'h00 || m1_err_o !== 0 || m0_err_o !== 0) begin errors++; $display("FAIL rd_m1quiet: got ack=%b dat=%h err=%b", m1_ack_o, m1_dat_o, m1_err_o); end
        @(negedge clk);
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        #1;
        checks++; if (m0_ack_o !== 0) begin errors++; $display("FAIL rd_ack_pulse: got %b want 0", m0_ack_o); end
        @(negedge clk); #1;
        checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL rd_release: got %b want 00", grant_o); end
    endtask

    task automatic test_round_robin;
        logic [1:0] g; bit idle;
        logic [1:0] exp_g [3] = '{2'b01, 2'b10, 2'b01};
        do_reset();
        @(negedge clk);
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        for (int k = 0; k < 3; k++) begin
            wait_grant(g, idle);
            checks++; if (g !== exp_g[k] || !idle) begin errors++; $display("FAIL rr_grant%0d: got %b idle=%0d want %b idle=1", k, g, idle, exp_g[k]); end
            s_ack_i = 1;
            #1;
            checks++; if ({m0_ack_o, m1_ack_o} !== {g[0], g[1]}) begin errors++; $display("FAIL rr_ack%0d: got %b%b", k, m0_ack_o, m1_ack_o); end
            @(negedge clk);
            s_ack_i = 0;
            if (g[0]) begin m0_cyc_i = 0; m0_stb_i = 0; end
            else      begin m1_cyc_i = 0; m1_stb_i = 0; end
            @(negedge clk);
            // re-request in the idle gap so both collide again
            m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        end
        clear_inputs();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_bus_lock;
        logic [1:0] g; bit idle;
        @(negedge clk);
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_adr_i = 16'h0010; m1_dat_i = 8'h11;
        @(negedge clk);
        wait_grant(g, idle);
        checks++; if (g !== 2'b10) begin errors++; $display("FAIL lock_grant1: got %b want 10", g); end
        m0_cyc_i = 1; m0_stb_i = 1;
        #1;
        checks++; if (s_adr_o !== 16'h0010 || s_dat_o !== 8'h11 || s_we_o !== 1) begin errors++; $display("FAIL lock_wr1: got adr=%h dat=%h we=%b", s_adr_o, s_dat_o, s_we_o); end
        s_ack_i = 1; #1;
        checks++; if (m1_ack_o !== 1 || m0_ack_o !== 0) begin errors++; $display("FAIL lock_ack1: got m1=%b m0=%b", m1_ack_o, m0_ack_o); end
        @(negedge clk);
        s_ack_i = 0; m1_stb_i = 0;
        @(negedge clk);
        m1_stb_i = 1; m1_adr_i = 16'h0011; m1_dat_i = 8'h22;
        #1;
        checks++; if (grant_o !== 2'b10 || s_adr_o !== 16'h0011 || s_dat_o !== 8'h22) begin errors++; $display("FAIL lock_wr2: got g=%b adr=%h dat=%h", grant_o, s_adr_o, s_dat_o); end
        s_ack_i = 1; #1;
        checks++; if (m1_ack_o !== 1 || m0_ack_o !== 0 || m0_err_o !== 0) begin errors++; $display("FAIL lock_ack2: got m1=%b m0=%b", m1_ack_o, m0_ack_o); end
        @(negedge clk);
        s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
        #1;
        checks++; if (grant_o !== 2'b10) begin errors++; $display("FAIL lock_hold: got %b want 10", grant_o); end
        @(negedge clk);
        wait_grant(g, idle);
        checks++; if (g !== 2'b01 || !idle) begin errors++; $display("FAIL lock_grant0: got %b idle=%0d want 01 idle=1", g, idle); end
        s_ack_i = 1;
        @(negedge clk);
        clear_inputs();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout;
        logic [1:0] g; bit idle;
        @(negedge clk);
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 16'hBEEF;
        @(negedge clk);
        wait_grant(g, idle);
        checks++; if (g !== 2'b01) begin errors++; $display("FAIL to_grant: got %b want 01", g); end
        for (int i = 0; i < TMO; i++) begin
            checks++; if (m0_err_o !== 0 || s_stb_o !== 1) begin errors++; $display("FAIL to_wait%0d: got err=%b stb=%b want 0 1", i, m0_err_o, s_stb_o); end
            @(negedge clk); #1;
        end
        checks++; if (m0_err_o !== 1 || s_stb_o !== 0 || s_cyc_o !== 0 || m1_err_o !== 0) begin errors++; $display("FAIL to_err: got err=%b stb=%b cyc=%b want 1 0 0", m0_err_o, s_stb_o, s_cyc_o); end
        @(negedge clk);
        s_ack_i = 1;
        #1;
        checks++; if (m0_err_o !== 0 || m0_ack_o !== 0 || s_stb_o !== 0 || grant_o !== 2'b01) begin errors++; $display("FAIL to_recover: got err=%b ack=%b stb=%b g=%b", m0_err_o, m0_ack_o, s_stb_o, grant_o); end
        @(negedge clk);
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        #1;
        checks++; if (grant_o !== 2'b01 || m0_err_o !== 0) begin errors++; $display("FAIL to_hold: got g=%b err=%b want 01 0", grant_o, m0_err_o); end
        @(negedge clk); #1;
        checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL to_idle: got %b want 00", grant_o); end
    endtask

    task automatic test_async_reset;
        logic [1:0] g; bit idle;
        @(negedge clk);
        m0_cyc_i = 1; m0_stb_i = 1;
        @(negedge clk);
        wait_grant(g, idle);
        checks++; if (g !== 2'b01) begin errors++; $display("FAIL ar_grant: got %b want 01", g); end
        s_ack_i = 1;
        #2;
        rst_n = 0;
        #1;
        checks++; if (grant_o !== 2'b00 || s_cyc_o !== 0 || m0_ack_o !== 0) begin errors++; $display("FAIL ar_abort: got g=%b cyc=%b ack=%b want 00 0 0", grant_o, s_cyc_o, m0_ack_o); end
        s_ack_i = 0;
        m1_cyc_i = 1; m1_stb_i = 1;
        @(negedge clk);
        #2 rst_n = 1;
        @(negedge clk);
        wait_grant(g, idle);
        checks++; if (g !== 2'b01 || idle) begin errors++; $display("FAIL ar_first: got %b idle=%0d want 01 idle=0", g, idle); end
        clear_inputs();
        repeat (2) @(negedge clk);
    endtask

    task automatic model_reset;
        mown = -1; mrec = 0; mlast = 1; mwait = 0; mfwd = 0; merr = 0;
    endtask

    task automatic model_expect(output logic [48:0] e);
        logic [1:0] eg; logic a0, a1, e0, e1, sc, ss, sw; logic [15:0] sa; logic [7:0] sd, d0, d1;
        logic oc, os;
        eg = 0; a0 = 0; a1 = 0; e0 = 0; e1 = 0; sc = 0; ss = 0; sw = 0; sa = 0; sd = 0; d0 = 0; d1 = 0;
        mfwd = 0; merr = 0;
        if (mown >= 0) begin
            oc = (mown == 1) ? m1_cyc_i : m0_cyc_i;
            os = (mown == 1) ? m1_stb_i : m0_stb_i;
            eg = (mown == 1) ? 2'b10 : 2'b01;
            if (mown == 1) d1 = s_dat_i; else d0 = s_dat_i;
            if (!mrec) begin
                mfwd = oc && os && s_ack_i;
                merr = oc && (mwait == TMO) && !mfwd;
                sc = oc && !merr;
                ss = os && !merr;
                sw = (mown == 1) ? m1_we_i : m0_we_i;
                sa = (mown == 1) ? m1_adr_i : m0_adr_i;
                sd = (mown == 1) ? m1_dat_i : m0_dat_i;
                if (mown == 1) begin a1 = mfwd; e1 = merr; end
                else           begin a0 = mfwd; e0 = merr; end
            end
        end
        e = {eg, a0, a1, e0, e1, sc, ss, sw, sa, sd, d0, d1};
    endtask

    task automatic model_step;
        bit r0, r1, oc, os;
        r0 = m0_cyc_i && m0_stb_i;
        r1 = m1_cyc_i && m1_stb_i;
        oc = (mown == 1) ? m1_cyc_i : m0_cyc_i;
        os = (mown == 1) ? m1_stb_i : m0_stb_i;
        if (mown < 0) begin
            if (r0 || r1) begin
                mown  = (r0 && r1) ? (mlast ? 0 : 1) : (r1 ? 1 : 0);
                mlast = (mown == 1);
                mwait = 0;
            end
        end else if (!mrec) begin
            if (!oc)                begin mown = -1; mwait = 0; end
            else if (merr)          begin mrec = 1; mwait = 0; end
            else if (mfwd || !os)   mwait = 0;
            else                    mwait++;
        end else if (!oc) begin
            mown = -1; mrec = 0;
        end
    endtask

    task automatic test_random;
        logic [48:0] exp_v, act_v;
        int bad;
        bad = 0;
        do_reset();
        model_reset();
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            m0_cyc_i = ($urandom_range(3) == 0) ? ~m0_cyc_i : m0_cyc_i;
            m1_cyc_i = ($urandom_range(3) == 0) ? ~m1_cyc_i : m1_cyc_i;
            m0_stb_i = m0_cyc_i && ($urandom_range(2) != 0);
            m1_stb_i = m1_cyc_i && ($urandom_range(2) != 0);
            m0_we_i  = ($urandom_range(1) == 1);
            m1_we_i  = ($urandom_range(1) == 1);
            m0_adr_i = 16'($urandom); m1_adr_i = 16'($urandom);
            m0_dat_i = 8'($urandom);  m1_dat_i = 8'($urandom);
            s_dat_i  = 8'($urandom);
            s_ack_i  = ($urandom_range(3) == 0);
            #1;
            model_expect(exp_v);
            act_v = {grant_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, s_cyc_o, s_stb_o, s_we_o,
                     s_adr_o, s_dat_o, m0_dat_o, m1_dat_o};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                if (bad < 10) $display("FAIL rand_cyc%0d: got %h want %h", n, act_v, exp_v);
                bad++;
            end
            model_step();
        end
        clear_inputs();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_bus_lock();
        test_timeout();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
